// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared writeback types and default configuration constants
//                for the execution-unit writeback path.
//                  XLEN                  datapath width
//                  wb_entry_t            one pending register-file write
//                  c_FIFO_DEPTH_DEFAULT  default secondary buffer depth
//                  c_STARVE_MAX_DEFAULT  default starvation threshold
//                  wb_rf_write           write-enable qualifier (x0 filter)
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   localparam int XLEN                 = 32;
   localparam int c_FIFO_DEPTH_DEFAULT = 2;
   localparam int c_STARVE_MAX_DEFAULT = 4;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] tag;
      logic [31:0]     instr;
   } wb_entry_t;

   // x0 is hard-wired to zero: a winner aimed at it is consumed but never written.
   function automatic logic wb_rf_write(input logic win, input logic [4:0] rd_addr);
      return win & (rd_addr != 5'd0);
   endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/dff_rst.sv
`default_nettype none
// ============================================================================
//  Module      : dff_rst
//  Description : Enabled D flip-flop bank with asynchronous active-low reset.
//  Ports       : clk    in  core clock
//                rst_n  in  asynchronous active-low reset
//                en     in  load enable (q holds when low)
//                d      in  next value
//                q      out registered value, RST_VAL during reset
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_rst #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : dff_rst
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous in-order FIFO of wb_entry_t. The head is
//                presented combinationally from storage; full/empty come
//                from the registered occupancy count. A push while full is
//                dropped, a pop while empty is ignored.
//  Ports       : clk        in  core clock
//                rst_n      in  asynchronous active-low reset (pointers/count)
//                push       in  write push_data at the tail
//                push_data  in  entry to store
//                pop        in  advance the head
//                full       out DEPTH entries held
//                empty      out no entries held
//                head       out oldest entry (undefined when empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = c_FIFO_DEPTH_DEFAULT
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int                c_PTR_W = $clog2(DEPTH);
   localparam int                c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

   wb_entry_t            r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;

   logic                 w_do_push;
   logic                 w_do_pop;

   assign full      = (r_count == c_FULL_CNT);
   assign empty     = (r_count == '0);
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;
   assign head      = r_mem[r_rd_ptr];

   // Storage carries no reset: validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/exu_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : exu_wb_arb
//  Description : Writeback arbiter behind the ALU. Merges the ALU result
//                stream (no handshake, always wins) with one buffered
//                secondary stream (LSU/MUL, valid/ready) onto the single
//                register-file write port. A starvation counter raises
//                alu_hold so the secondary buffer is guaranteed to drain.
//  Config      : WB_TRACE_EN - adds registered retire_valid/retire_tag/
//                retire_instr outputs aligned with rf_*.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                alu_wb_*/alu_instr*        ALU writeback (valid = rd_wr_en)
//                sec_valid/sec_ready        secondary handshake
//                sec_data/rd_addr/instr*    secondary writeback payload
//                alu_hold                   no ALU writeback next cycle
//                rf_wr_en/addr/data         registered RF write port
//                retire_*                   trace outputs (WB_TRACE_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module exu_wb_arb
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = c_FIFO_DEPTH_DEFAULT,
   parameter int STARVE_MAX = c_STARVE_MAX_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] alu_wb_data,
   input  logic [4:0]      alu_wb_rd_addr,
   input  logic            alu_wb_rd_wr_en,
   input  logic [XLEN-1:0] alu_instr_tag,
   input  logic [31:0]     alu_instr,
   input  logic            sec_valid,
   output logic            sec_ready,
   input  logic [XLEN-1:0] sec_data,
   input  logic [4:0]      sec_rd_addr,
   input  logic [XLEN-1:0] sec_instr_tag,
   input  logic [31:0]     sec_instr,
   output logic            alu_hold,
   output logic            rf_wr_en,
   output logic [4:0]      rf_wr_addr,
   output logic [XLEN-1:0] rf_wr_data
`ifdef WB_TRACE_EN
   ,
   output logic            retire_valid,
   output logic [XLEN-1:0] retire_tag,
   output logic [31:0]     retire_instr
`endif
);

   localparam int                   c_STARVE_W     = $clog2(STARVE_MAX + 1);
   localparam logic [c_STARVE_W-1:0] c_STARVE_LIMIT = c_STARVE_W'(STARVE_MAX);

   wb_entry_t             w_alu_entry;
   wb_entry_t             w_sec_entry;
   wb_entry_t             w_head;
   wb_entry_t             w_win_entry;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_win;
   logic                  w_rf_wr_en_d;
   logic                  w_hold_d;
   logic                  r_ready_en;
   logic [c_STARVE_W-1:0] r_starve;
   logic [c_STARVE_W-1:0] w_starve_d;

   always_comb begin
      w_alu_entry         = '0;
      w_alu_entry.data    = alu_wb_data;
      w_alu_entry.rd_addr = alu_wb_rd_addr;
      w_alu_entry.tag     = alu_instr_tag;
      w_alu_entry.instr   = alu_instr;

      w_sec_entry         = '0;
      w_sec_entry.data    = sec_data;
      w_sec_entry.rd_addr = sec_rd_addr;
      w_sec_entry.tag     = sec_instr_tag;
      w_sec_entry.instr   = sec_instr;
   end

   // ------------------------------------------------------------------------
   // Secondary buffer. sec_ready is held low through reset and rises on the
   // first clock after release, then tracks ~full of the registered count.
   // ------------------------------------------------------------------------
   dff_rst #(.WIDTH(1)) u_ready_en (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .d     (1'b1),
      .q     (r_ready_en)
   );

   assign sec_ready = r_ready_en & ~w_full;
   assign w_push    = sec_valid & sec_ready;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_sec_entry),
      .pop       (w_pop),
      .full      (w_full),
      .empty     (w_empty),
      .head      (w_head)
   );

   // ------------------------------------------------------------------------
   // Arbitration: the ALU cannot stall, so it always wins; the FIFO head
   // only pops in cycles the ALU leaves free. An entry pushed this cycle is
   // not yet visible as head, so it wins one cycle later at the earliest.
   // ------------------------------------------------------------------------
   assign w_pop        = ~alu_wb_rd_wr_en & ~w_empty;
   assign w_win        = alu_wb_rd_wr_en | w_pop;
   assign w_win_entry  = alu_wb_rd_wr_en ? w_alu_entry : w_head;
   assign w_rf_wr_en_d = wb_rf_write(w_win, w_win_entry.rd_addr);

   dff_rst #(.WIDTH(1)) u_rf_wr_en (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .d     (w_rf_wr_en_d),
      .q     (rf_wr_en)
   );

   // Address/data only load on a winner so they hold through idle cycles.
   dff_rst #(.WIDTH(5)) u_rf_wr_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_win),
      .d     (w_win_entry.rd_addr),
      .q     (rf_wr_addr)
   );

   dff_rst #(.WIDTH(XLEN)) u_rf_wr_data (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_win),
      .d     (w_win_entry.data),
      .q     (rf_wr_data)
   );

   // ------------------------------------------------------------------------
   // Starvation: count cycles the ALU blocks a waiting head, saturating at
   // STARVE_MAX. alu_hold is set from the next count so it appears in the
   // cycle right after the limiting blocked cycle, and it is sticky until
   // the head actually pops.
   // ------------------------------------------------------------------------
   always_comb begin
      w_starve_d = r_starve;
      if (w_pop) begin
         w_starve_d = '0;
      end else if (alu_wb_rd_wr_en && !w_empty && (r_starve != c_STARVE_LIMIT)) begin
         w_starve_d = r_starve + c_STARVE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else begin
         r_starve <= w_starve_d;
      end
   end

   assign w_hold_d = ~w_pop & (alu_hold | (w_starve_d == c_STARVE_LIMIT));

   dff_rst #(.WIDTH(1)) u_alu_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .d     (w_hold_d),
      .q     (alu_hold)
   );

`ifdef WB_TRACE_EN
   // Retire trace covers every winner, x0 included, aligned with rf_*.
   dff_rst #(.WIDTH(1)) u_retire_valid (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .d     (w_win),
      .q     (retire_valid)
   );

   dff_rst #(.WIDTH(XLEN)) u_retire_tag (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_win),
      .d     (w_win_entry.tag),
      .q     (retire_tag)
   );

   dff_rst #(.WIDTH(32)) u_retire_instr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_win),
      .d     (w_win_entry.instr),
      .q     (retire_instr)
   );
`else
   // Tag and instruction only feed the retire trace.
   logic w_unused_trace;
   assign w_unused_trace = ^{w_win_entry.tag, w_win_entry.instr};
`endif

`ifndef SYNTHESIS
   // The ALU cannot stall: a writeback under alu_hold still wins, but it
   // means issue ignored the hold.
   a_alu_hold_respected : assert property (
      @(posedge clk) disable iff (!rst_n) !(alu_hold && alu_wb_rd_wr_en));
`endif

endmodule : exu_wb_arb
`default_nettype wire

// File: tb/tb_exu_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exu_wb_arb
//  Description : Directed self-checking bench for exu_wb_arb. Expected RF
//                writes (cycle, address, data) are queued as stimulus is
//                driven and popped by a negedge monitor on each rf_wr_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_wb_arb;
   import wb_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [XLEN-1:0] alu_wb_data;
   logic [4:0]      alu_wb_rd_addr;
   logic            alu_wb_rd_wr_en;
   logic [XLEN-1:0] alu_instr_tag;
   logic [31:0]     alu_instr;
   logic            sec_valid;
   logic            sec_ready;
   logic [XLEN-1:0] sec_data;
   logic [4:0]      sec_rd_addr;
   logic [XLEN-1:0] sec_instr_tag;
   logic [31:0]     sec_instr;
   logic            alu_hold;
   logic            rf_wr_en;
   logic [4:0]      rf_wr_addr;
   logic [XLEN-1:0] rf_wr_data;
`ifdef WB_TRACE_EN
   logic            retire_valid;
   logic [XLEN-1:0] retire_tag;
   logic [31:0]     retire_instr;
`endif

   always #5 clk = ~clk;

   exu_wb_arb dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alu_wb_data     (alu_wb_data),
      .alu_wb_rd_addr  (alu_wb_rd_addr),
      .alu_wb_rd_wr_en (alu_wb_rd_wr_en),
      .alu_instr_tag   (alu_instr_tag),
      .alu_instr       (alu_instr),
      .sec_valid       (sec_valid),
      .sec_ready       (sec_ready),
      .sec_data        (sec_data),
      .sec_rd_addr     (sec_rd_addr),
      .sec_instr_tag   (sec_instr_tag),
      .sec_instr       (sec_instr),
      .alu_hold        (alu_hold),
      .rf_wr_en        (rf_wr_en),
      .rf_wr_addr      (rf_wr_addr),
      .rf_wr_data      (rf_wr_data)
`ifdef WB_TRACE_EN
      ,
      .retire_valid    (retire_valid),
      .retire_tag      (retire_tag),
      .retire_instr    (retire_instr)
`endif
   );

   typedef struct {
      int              cyc;
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   cyc       = 0;
   int   n_cmp     = 0;
   int   n_err     = 0;
   bit   mon_en    = 1'b0;
   logic exp_hold  = 1'b0;
   int   t0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      assert (got === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
      end
   endtask

   task automatic expect_wr(input int c, input logic [4:0] a, input logic [XLEN-1:0] d);
      exp_t e;
      e.cyc  = c;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ae, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                        input logic sv, input logic [4:0] srd, input logic [XLEN-1:0] sd);
      alu_wb_rd_wr_en = ae;
      alu_wb_rd_addr  = ard;
      alu_wb_data     = ad;
      alu_instr_tag   = ad ^ 32'h0F0F_0000;
      alu_instr       = {27'd0, ard};
      sec_valid       = sv;
      sec_rd_addr     = srd;
      sec_data        = sd;
      sec_instr_tag   = sd ^ 32'h00F0_F000;
      sec_instr       = {27'd1, srd};
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   // Monitor: every RF write must match the oldest queued expectation,
   // including the cycle it lands in; alu_hold is tracked every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         check("alu_hold", alu_hold, exp_hold);
         if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("rf_wr_en_unexpected", rf_wr_en, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("rf_wr_cycle", cyc, e.cyc);
               check("rf_wr_addr", rf_wr_addr, e.addr);
               check("rf_wr_data", rf_wr_data, e.data);
            end
         end
      end
   end

   initial begin
      // ---------------- reset ----------------
      rst_n = 1'b0;
      idle();
      repeat (3) tick();
      check("rst_rf_wr_en", rf_wr_en, 1'b0);
      check("rst_rf_wr_addr", rf_wr_addr, 5'd0);
      check("rst_rf_wr_data", rf_wr_data, 32'd0);
      check("rst_alu_hold", alu_hold, 1'b0);
      check("rst_sec_ready", sec_ready, 1'b0);
`ifdef WB_TRACE_EN
      check("rst_retire_valid", retire_valid, 1'b0);
`endif
      rst_n = 1'b1;
      check("sec_ready_at_release", sec_ready, 1'b0);
      tick();
      check("sec_ready_after_release", sec_ready, 1'b1);
      mon_en = 1'b1;

      // ---------------- 1: ALU only, 1-cycle latency, idle hold ----------------
      t0 = cyc;
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, '0);
      expect_wr(t0 + 1, 5'd5, 32'hDEAD_BEEF);
      tick();
      idle();
      tick();
      check("idle_rf_wr_en", rf_wr_en, 1'b0);
      check("idle_hold_addr", rf_wr_addr, 5'd5);
      check("idle_hold_data", rf_wr_data, 32'hDEAD_BEEF);

      // ---------------- 2: secondary only, 2-cycle latency ----------------
      t0 = cyc;
      check("t2_ready0", sec_ready, 1'b1);
      drive(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h0000_1234);
      expect_wr(t0 + 2, 5'd7, 32'h0000_1234);
      tick();
      check("t2_ready1", sec_ready, 1'b1);
      idle();
      repeat (2) tick();
      check("t2_ready2", sec_ready, 1'b1);

      // ---------------- 3: contention, no hold ----------------
      t0 = cyc;
      drive(1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd9, 32'h0000_0909);
      expect_wr(t0 + 1, 5'd1, 32'h0000_0101);
      tick();
      drive(1'b1, 5'd2, 32'h0000_0202, 1'b0, 5'd0, '0);
      expect_wr(t0 + 2, 5'd2, 32'h0000_0202);
      tick();
      drive(1'b1, 5'd3, 32'h0000_0303, 1'b0, 5'd0, '0);
      expect_wr(t0 + 3, 5'd3, 32'h0000_0303);
      expect_wr(t0 + 4, 5'd9, 32'h0000_0909);
      tick();
      idle();
      repeat (3) tick();

      // ---------------- 4: starvation raises alu_hold ----------------
      t0 = cyc;
      drive(1'b1, 5'd10, 32'h0000_00A0, 1'b1, 5'd11, 32'h0000_00B1);
      expect_wr(t0 + 1, 5'd10, 32'h0000_00A0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(12 + i), 32'h0000_0C00 + i, 1'b0, 5'd0, '0);
         expect_wr(t0 + 2 + i, 5'(12 + i), 32'h0000_0C00 + i);
         tick();
      end
      exp_hold = 1'b1;
      idle();
      expect_wr(t0 + 6, 5'd11, 32'h0000_00B1);
      tick();
      exp_hold = 1'b0;
      repeat (2) tick();

      // ---------------- 5: full, no push on pop, order on drain ----------------
      t0 = cyc;
      drive(1'b1, 5'd1, 32'h0000_1001, 1'b1, 5'd20, 32'h0000_2020);
      expect_wr(t0 + 1, 5'd1, 32'h0000_1001);
      tick();
      check("t5_ready_after_1", sec_ready, 1'b1);
      drive(1'b1, 5'd2, 32'h0000_1002, 1'b1, 5'd21, 32'h0000_2121);
      expect_wr(t0 + 2, 5'd2, 32'h0000_1002);
      tick();
      check("t5_ready_full", sec_ready, 1'b0);
      drive(1'b1, 5'd3, 32'h0000_1003, 1'b1, 5'd22, 32'h0000_2222);
      expect_wr(t0 + 3, 5'd3, 32'h0000_1003);
      tick();
      check("t5_ready_full_on_pop", sec_ready, 1'b0);
      drive(1'b0, 5'd0, '0, 1'b1, 5'd22, 32'h0000_2222);
      expect_wr(t0 + 4, 5'd20, 32'h0000_2020);
      tick();
      check("t5_ready_after_pop", sec_ready, 1'b1);
      expect_wr(t0 + 5, 5'd21, 32'h0000_2121);
      tick();
      check("t5_ready_push_pop", sec_ready, 1'b1);
      idle();
      expect_wr(t0 + 6, 5'd22, 32'h0000_2222);
      repeat (3) tick();

      // ---------------- 6a: x0 winners consume their slot ----------------
      t0 = cyc;
      drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h0000_0055);
      tick();
      drive(1'b0, 5'd0, '0, 1'b1, 5'd23, 32'h0000_2323);
      tick();
      check("x0_sec_rf_wr_en", rf_wr_en, 1'b0);
`ifdef WB_TRACE_EN
      check("x0_sec_retire_valid", retire_valid, 1'b1);
`endif
      drive(1'b1, 5'd0, 32'h0000_0077, 1'b0, 5'd0, '0);
      expect_wr(t0 + 4, 5'd23, 32'h0000_2323);
      tick();
      check("x0_alu_rf_wr_en", rf_wr_en, 1'b0);
`ifdef WB_TRACE_EN
      check("x0_alu_retire_valid", retire_valid, 1'b1);
`endif
      idle();
      repeat (3) tick();

      // ---------------- 6b: reset with two entries buffered ----------------
      t0 = cyc;
      drive(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd24, 32'h0000_2424);
      expect_wr(t0 + 1, 5'd1, 32'h0000_00A1);
      tick();
      drive(1'b1, 5'd0, 32'h0000_00B2, 1'b1, 5'd25, 32'h0000_2525);
      tick();
      check("t6_full_before_rst", sec_ready, 1'b0);
      idle();
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("midrst_rf_wr_en", rf_wr_en, 1'b0);
      check("midrst_rf_wr_addr", rf_wr_addr, 5'd0);
      check("midrst_rf_wr_data", rf_wr_data, 32'd0);
      check("midrst_alu_hold", alu_hold, 1'b0);
      check("midrst_sec_ready", sec_ready, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      exp_hold = 1'b0;
      mon_en   = 1'b1;
      check("postrst_sec_ready", sec_ready, 1'b1);
      t0 = cyc;
      drive(1'b0, 5'd0, '0, 1'b1, 5'd26, 32'h0000_2626);
      expect_wr(t0 + 2, 5'd26, 32'h0000_2626);
      tick();
      idle();
      repeat (5) tick();

      check("exp_q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_exu_wb_arb
`default_nettype wire
